// File: rtl/multicore_pkg.sv
// multicore_pkg: shared types for the core's hazard control (scoreboard slots, FSM states, forward sources).
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package multicore_pkg;

    // Scoreboard slots carry a fixed-width rd; NUM_REGS on hazard_ctrl must not exceed this.
    localparam int HZ_MAX_REGS = 32;
    localparam int HZ_RD_W     = $clog2(HZ_MAX_REGS);

    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               regwrite;
        logic               is_load;
    } t_hz_slot;

    typedef enum logic {
        HZ_RUN,
        HZ_DRAIN
    } t_hz_state;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EX,
        FWD_MEM,
        FWD_WB
    } t_fwd_src;

    // A slot supplies an operand only if it really writes that register; x0 is never a producer.
    function automatic logic hz_slot_hit(input t_hz_slot s, input logic [HZ_RD_W-1:0] rs,
                                         input logic use_rs);
        return s.valid && s.regwrite && (s.rd == rs) && (rs != '0) && use_rs;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: one operand's producer search over EX/MEM/WB with EX > MEM > WB priority and data mux.
// Latency: purely combinational.
// Backpressure: none; reports whether the winning producer is a load so the caller can stall.
module hazard_fwd_sel
    import multicore_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic [HZ_RD_W-1:0]   i_rs,
    input  logic                 i_use_rs,
    input  t_hz_slot             i_slot_ex,
    input  t_hz_slot             i_slot_mem,
    input  t_hz_slot             i_slot_wb,
    input  logic [DATA_SIZE-1:0] i_ex_data,
    input  logic [DATA_SIZE-1:0] i_mem_data,
    input  logic [DATA_SIZE-1:0] i_wb_data,
    output t_fwd_src             o_src,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_load_hit
);

    // Youngest producer wins; o_load_hit reflects the winning slot only.
    always_comb begin
        o_src      = FWD_NONE;
        o_data     = '0;
        o_load_hit = 1'b0;
        if (hz_slot_hit(i_slot_ex, i_rs, i_use_rs)) begin
            o_src      = FWD_EX;
            o_data     = i_ex_data;
            o_load_hit = i_slot_ex.is_load;
        end else if (hz_slot_hit(i_slot_mem, i_rs, i_use_rs)) begin
            o_src      = FWD_MEM;
            o_data     = i_mem_data;
            o_load_hit = i_slot_mem.is_load;
        end else if (hz_slot_hit(i_slot_wb, i_rs, i_use_rs)) begin
            o_src      = FWD_WB;
            o_data     = i_wb_data;
            o_load_hit = i_slot_wb.is_load;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX/MEM/WB destination scoreboard driving decode forwarding, load-use stalls, squashes and drains.
// Latency: all controls and forward data combinational; slots and RUN/DRAIN state advance on i_aclk.
// Backpressure: holds fetch/decode and bubbles EX on load-use or drain; an EX redirect overrides any hold.
// Build option: define HAZARD_PERF_EN to add saturating o_stall_cycles / o_flush_count counters.
module hazard_ctrl
    import multicore_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int DATA_SIZE = 32
) (
    input  logic                        i_aclk,
    input  logic                        i_areset,
    input  logic                        i_id_valid,
    input  logic [$clog2(NUM_REGS)-1:0] i_id_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] i_id_rs2,
    input  logic                        i_id_use_rs1,
    input  logic                        i_id_use_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] i_id_rd,
    input  logic                        i_id_regwrite,
    input  logic [1:0]                  i_id_memtoreg,
    input  logic                        i_id_jal,
    input  logic                        i_id_drain,
    input  logic                        i_ex_redirect,
    input  logic [DATA_SIZE-1:0]        i_ex_fwd_data,
    input  logic [DATA_SIZE-1:0]        i_mem_fwd_data,
    input  logic [DATA_SIZE-1:0]        i_wb_data,
    output logic                        o_forward_a,
    output logic                        o_forward_b,
    output logic [DATA_SIZE-1:0]        o_fdata_a,
    output logic [DATA_SIZE-1:0]        o_fdata_b,
    output logic                        o_hold_if,
    output logic                        o_hold_id,
    output logic                        o_id_en,
    output logic                        o_bubble_ex
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                 o_stall_cycles,
    output logic [31:0]                 o_flush_count
`endif
);

    t_hz_slot             slot_ex, slot_mem, slot_wb;
    t_hz_state            state_q, state_d;
    t_fwd_src             src_a, src_b;
    logic [DATA_SIZE-1:0] data_a, data_b;
    logic                 load_a, load_b;
    logic                 load_use, any_valid, drain_hold, hold_req;
    logic [HZ_RD_W-1:0]   rs1_w, rs2_w, rd_w;

    assign rs1_w = HZ_RD_W'(i_id_rs1);
    assign rs2_w = HZ_RD_W'(i_id_rs2);
    assign rd_w  = HZ_RD_W'(i_id_rd);

    hazard_fwd_sel #(.DATA_SIZE(DATA_SIZE)) u_fwd_a (
        .i_rs       (rs1_w),
        .i_use_rs   (i_id_use_rs1),
        .i_slot_ex  (slot_ex),
        .i_slot_mem (slot_mem),
        .i_slot_wb  (slot_wb),
        .i_ex_data  (i_ex_fwd_data),
        .i_mem_data (i_mem_fwd_data),
        .i_wb_data  (i_wb_data),
        .o_src      (src_a),
        .o_data     (data_a),
        .o_load_hit (load_a)
    );

    hazard_fwd_sel #(.DATA_SIZE(DATA_SIZE)) u_fwd_b (
        .i_rs       (rs2_w),
        .i_use_rs   (i_id_use_rs2),
        .i_slot_ex  (slot_ex),
        .i_slot_mem (slot_mem),
        .i_slot_wb  (slot_wb),
        .i_ex_data  (i_ex_fwd_data),
        .i_mem_data (i_mem_fwd_data),
        .i_wb_data  (i_wb_data),
        .o_src      (src_b),
        .o_data     (data_b),
        .o_load_hit (load_b)
    );

    // Load data only exists from WB onward, so a winning load in EX or MEM must stall.
    assign load_use = (load_a && ((src_a == FWD_EX) || (src_a == FWD_MEM))) ||
                      (load_b && ((src_b == FWD_EX) || (src_b == FWD_MEM)));

    assign any_valid = slot_ex.valid || slot_mem.valid || slot_wb.valid;

    // A drain already holds in the request cycle and keeps holding until the pipe behind decode is empty.
    assign drain_hold = (state_q == HZ_DRAIN) ? any_valid
                                              : (i_id_valid && i_id_drain && any_valid);

    assign hold_req = load_use || drain_hold;

    // Forwarding is withheld while decode is held; the held instruction re-resolves its operands later.
    assign o_forward_a = (src_a != FWD_NONE) && !hold_req;
    assign o_forward_b = (src_b != FWD_NONE) && !hold_req;
    assign o_fdata_a   = o_forward_a ? data_a : '0;
    assign o_fdata_b   = o_forward_b ? data_b : '0;

    // Squash priority: redirect, then stall/drain, then JAL; also computes RUN/DRAIN next state.
    always_comb begin
        state_d     = state_q;
        o_hold_if   = 1'b0;
        o_hold_id   = 1'b0;
        o_id_en     = 1'b1;
        o_bubble_ex = 1'b0;
        case (state_q)
            HZ_RUN:   if (drain_hold) state_d = HZ_DRAIN;
            HZ_DRAIN: if (!any_valid) state_d = HZ_RUN;
            default:  state_d = HZ_RUN;
        endcase
        if (i_ex_redirect) begin
            o_id_en     = 1'b0;
            o_bubble_ex = 1'b1;
            state_d     = HZ_RUN;
        end else if (hold_req) begin
            o_hold_if   = 1'b1;
            o_hold_id   = 1'b1;
            o_bubble_ex = 1'b1;
        end else if (i_id_jal) begin
            o_id_en = 1'b0;
        end
    end

    // Scoreboard shifts every cycle; EX captures decode only when a real instruction issues.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            slot_ex  <= '0;
            slot_mem <= '0;
            slot_wb  <= '0;
            state_q  <= HZ_RUN;
        end else begin
            slot_wb  <= slot_mem;
            slot_mem <= slot_ex;
            if (i_id_valid && !o_bubble_ex) begin
                slot_ex.valid    <= 1'b1;
                slot_ex.rd       <= rd_w;
                slot_ex.regwrite <= i_id_regwrite;
                slot_ex.is_load  <= (i_id_memtoreg == MEMTOREG_LOAD);
            end else begin
                slot_ex <= '0;
            end
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counts of held-decode cycles and redirect/JAL squash cycles.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            o_stall_cycles <= '0;
            o_flush_count  <= '0;
        end else begin
            if (o_hold_id && (o_stall_cycles != '1)) o_stall_cycles <= o_stall_cycles + 32'd1;
            if (!o_id_en && (o_flush_count != '1))   o_flush_count  <= o_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table, hand sequences for redirect/drain/reset corners, random vs reference model.
// Latency: checks sample combinational outputs 1 ns after inputs change at the falling edge.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic        id_valid, use1, use2, regwrite, jal, drain, redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  memtoreg;
    logic [31:0] ex_d, mem_d, wb_d;
    logic        fwd_a, fwd_b, hold_if, hold_id, id_en, bubble_ex;
    logic [31:0] fdata_a, fdata_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    hazard_ctrl #(.NUM_REGS(32), .DATA_SIZE(32)) dut (
        .i_aclk         (clk),
        .i_areset       (areset),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (use1),
        .i_id_use_rs2   (use2),
        .i_id_rd        (id_rd),
        .i_id_regwrite  (regwrite),
        .i_id_memtoreg  (memtoreg),
        .i_id_jal       (jal),
        .i_id_drain     (drain),
        .i_ex_redirect  (redirect),
        .i_ex_fwd_data  (ex_d),
        .i_mem_fwd_data (mem_d),
        .i_wb_data      (wb_d),
        .o_forward_a    (fwd_a),
        .o_forward_b    (fwd_b),
        .o_fdata_a      (fdata_a),
        .o_fdata_b      (fdata_b),
        .o_hold_if      (hold_if),
        .o_hold_id      (hold_id),
        .o_id_en        (id_en),
        .o_bubble_ex    (bubble_ex)
`ifdef HAZARD_PERF_EN
        ,
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic [4:0] rd, input logic rw, input logic [1:0] m2r,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic j, input logic dr, input logic rdr);
        id_valid = vld; id_rd = rd; regwrite = rw; memtoreg = m2r;
        id_rs1 = rs1; use1 = u1; id_rs2 = rs2; use2 = u2;
        jal = j; drain = dr; redirect = rdr;
    endtask

    task automatic chk_ctl(input string tag, input logic e_hold, input logic e_iden, input logic e_bub);
        chk({tag, " hold_if"}, 32'(hold_if), 32'(e_hold));
        chk({tag, " hold_id"}, 32'(hold_id), 32'(e_hold));
        chk({tag, " id_en"}, 32'(id_en), 32'(e_iden));
        chk({tag, " bubble_ex"}, 32'(bubble_ex), 32'(e_bub));
    endtask

    task automatic do_reset;
        @(negedge clk);
        areset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        areset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic vld; logic [4:0] rd; logic rw; logic [1:0] m2r;
        logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2; logic j;
        logic fa; logic [31:0] da; logic fb; logic [31:0] db;
        logic hold; logic bub; logic iden;
    } vec_t;

    function automatic vec_t mkv(input logic vld, input logic [4:0] rd, input logic rw, input logic [1:0] m2r,
                                 input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                                 input logic j, input logic fa, input logic [31:0] da, input logic fb,
                                 input logic [31:0] db, input logic hold, input logic bub, input logic iden);
        vec_t v;
        v.vld = vld; v.rd = rd; v.rw = rw; v.m2r = m2r; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.j = j; v.fa = fa; v.da = da; v.fb = fb; v.db = db; v.hold = hold; v.bub = bub; v.iden = iden;
        return v;
    endfunction

    vec_t tbl[20];

    // ---------------- reference model ----------------
    typedef struct { logic v; logic [4:0] rd; logic rw; logic ld; } rec_t;
    rec_t        pipe[$];          // [0]=EX, [1]=MEM, [2]=WB
    logic        m_draining;
    logic [31:0] m_stall, m_flush;
    logic        e_fa, e_fb, e_hold, e_iden, e_bub;
    logic [31:0] e_da, e_db;

    function automatic void m_reset();
        rec_t z;
        z.v = 0; z.rd = 0; z.rw = 0; z.ld = 0;
        pipe.delete();
        for (int k = 0; k < 3; k++) pipe.push_back(z);
        m_draining = 0; m_stall = 0; m_flush = 0;
    endfunction

    function automatic void m_fwd(input logic [4:0] rs, input logic u, output logic hit,
                                  output logic [31:0] data, output logic stall);
        hit = 0; data = 0; stall = 0;
        for (int k = 0; k < 3; k++) begin
            if (!hit && pipe[k].v && pipe[k].rw && pipe[k].rd == rs && rs != 0 && u) begin
                hit   = 1;
                data  = (k == 0) ? ex_d : (k == 1) ? mem_d : wb_d;
                stall = pipe[k].ld && (k < 2);
            end
        end
    endfunction

    function automatic void m_eval();
        logic ha, hb, sa, sb, any, dh;
        logic [31:0] da, db;
        m_fwd(id_rs1, use1, ha, da, sa);
        m_fwd(id_rs2, use2, hb, db, sb);
        any    = pipe[0].v || pipe[1].v || pipe[2].v;
        dh     = m_draining ? any : (id_valid && drain && any);
        e_hold = 0; e_iden = 1; e_bub = 0;
        if (redirect) begin e_iden = 0; e_bub = 1; end
        else if (sa || sb || dh) begin e_hold = 1; e_bub = 1; end
        else if (jal) e_iden = 0;
        e_fa = ha && !(sa || sb || dh);
        e_fb = hb && !(sa || sb || dh);
        e_da = e_fa ? da : 0;
        e_db = e_fb ? db : 0;
        m_draining = !redirect && dh;   // takes effect after m_step's edge
    endfunction

    function automatic void m_step();
        rec_t n;
        if (areset) begin
            m_reset();
        end else begin
            n.v = id_valid && !e_bub; n.rd = n.v ? id_rd : 0; n.rw = n.v && regwrite;
            n.ld = n.v && (memtoreg == 2'b01);
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (e_hold && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (!e_iden && m_flush != 32'hFFFF_FFFF) m_flush++;
        end
    endfunction

    initial begin
        areset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_d = 32'h1234; mem_d = 32'h5678; wb_d = 32'hCAFE;

        // rd, rw, m2r | rs1,u1, rs2,u2, jal | fa,da, fb,db | hold, bub, id_en
        tbl[0]  = mkv(1, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        tbl[1]  = mkv(1, 6, 1, 0,  5, 1, 0, 1, 0,  1, 32'h1234, 0, 0,  0, 0, 1);
        tbl[2]  = mkv(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = mkv(1, 7, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        tbl[6]  = mkv(1, 8, 1, 0,  7, 1, 7, 1, 0,  0, 0, 0, 0,  1, 1, 1);
        tbl[7]  = tbl[6];
        tbl[8]  = mkv(1, 8, 1, 0,  7, 1, 7, 1, 0,  1, 32'hCAFE, 1, 32'hCAFE,  0, 0, 1);
        tbl[9]  = mkv(1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        tbl[10] = mkv(1, 3, 1, 0,  0, 1, 8, 1, 0,  0, 0, 1, 32'h5678,  0, 0, 1);
        tbl[11] = mkv(1, 3, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        tbl[12] = mkv(1, 9, 1, 0,  3, 1, 3, 1, 0,  1, 32'h1234, 1, 32'h1234,  0, 0, 1);
        tbl[13] = mkv(1, 1, 1, 2,  0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0);
        tbl[14] = mkv(1, 0, 0, 0,  1, 1, 0, 0, 0,  1, 32'h1234, 0, 0,  0, 0, 1);
        tbl[15] = mkv(1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        tbl[16] = mkv(1, 10, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        tbl[17] = tbl[2];
        tbl[18] = mkv(1, 11, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1);
        tbl[19] = mkv(1, 11, 1, 0, 10, 1, 0, 0, 0, 1, 32'hCAFE, 0, 0,  0, 0, 1);

        // Reset state
        do_reset();
        @(negedge clk); #1;
        chk_ctl("reset", 0, 1, 0);
        chk("reset fwd_a", 32'(fwd_a), 0);
        chk("reset fdata_b", fdata_b, 0);
`ifdef HAZARD_PERF_EN
        chk("reset stall_cycles", stall_cycles, 0);
        chk("reset flush_count", flush_count, 0);
`endif

        // Directed table
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].rd, tbl[i].rw, tbl[i].m2r, tbl[i].rs1, tbl[i].u1,
                  tbl[i].rs2, tbl[i].u2, tbl[i].j, 0, 0);
            #1;
            chk($sformatf("t%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
            chk($sformatf("t%0d fdata_a", i), fdata_a, tbl[i].da);
            chk($sformatf("t%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
            chk($sformatf("t%0d fdata_b", i), fdata_b, tbl[i].db);
            chk_ctl($sformatf("t%0d", i), tbl[i].hold, tbl[i].iden, tbl[i].bub);
        end

        // Redirect in the first cycle of a load-use stall
        do_reset();
        @(negedge clk); drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 8, 1, 0, 7, 1, 7, 1, 0, 0, 1); #1;
        chk_ctl("redir_stall", 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk_ctl("redir_after", 0, 1, 0);

        // Fence drain behind three valid slots
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); drive(1, 5'(k), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
            chk_ctl($sformatf("drain c%0d", k), (k < 3), 1, (k < 3));
        end
        @(negedge clk); drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk_ctl("drain run", 0, 1, 0);

        // Redirect cancels DRAIN: afterwards a valid WB slot must not hold a plain instruction
        do_reset();
        @(negedge clk); drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk_ctl("drain req", 1, 1, 1);
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
        chk_ctl("drain redir", 0, 0, 1);
        @(negedge clk); drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk_ctl("drain redir after", 0, 1, 0);

        // Reset pulsed mid-stall clears everything on the next cycle
        do_reset();
        @(negedge clk); drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 8, 1, 0, 7, 1, 0, 0, 0, 0, 0); areset = 1'b1; #1;
        chk_ctl("rst mid-stall", 1, 1, 1);
        @(negedge clk); areset = 1'b0; #1;
        chk_ctl("rst after", 0, 1, 0);
        chk("rst after fwd_a", 32'(fwd_a), 0);

`ifdef HAZARD_PERF_EN
        // Counters: a 2-cycle load-use stall then one JAL squash
        do_reset();
        @(negedge clk); drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 8, 1, 0, 7, 1, 7, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); drive(1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("perf stall_cycles", stall_cycles, 2);
        chk("perf flush_count", flush_count, 1);
        @(negedge clk); drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 8, 1, 0, 7, 1, 0, 0, 0, 0, 0); areset = 1'b1;
        @(negedge clk); areset = 1'b0; #1;
        chk("perf rst stall_cycles", stall_cycles, 0);
        chk("perf rst flush_count", flush_count, 0);
        chk("perf rst id_en", 32'(id_en), 1);
`endif

        // Random traffic against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            areset   = ($urandom_range(0, 80) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            id_rd    = 5'($urandom_range(0, 3));
            regwrite = ($urandom_range(0, 3) != 0);
            memtoreg = 2'($urandom_range(0, 2));
            id_rs1   = 5'($urandom_range(0, 3));
            id_rs2   = 5'($urandom_range(0, 3));
            use1     = 1'($urandom_range(0, 1));
            use2     = 1'($urandom_range(0, 1));
            jal      = ($urandom_range(0, 7) == 0);
            drain    = ($urandom_range(0, 11) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            ex_d     = $urandom;
            mem_d    = $urandom;
            wb_d     = $urandom;
            #1;
`ifdef HAZARD_PERF_EN
            chk($sformatf("rnd%0d stall_cycles", c), stall_cycles, m_stall);
            chk($sformatf("rnd%0d flush_count", c), flush_count, m_flush);
`endif
            m_eval();
            chk($sformatf("rnd%0d fwd_a", c), 32'(fwd_a), 32'(e_fa));
            chk($sformatf("rnd%0d fdata_a", c), fdata_a, e_da);
            chk($sformatf("rnd%0d fwd_b", c), 32'(fwd_b), 32'(e_fb));
            chk($sformatf("rnd%0d fdata_b", c), fdata_b, e_db);
            chk_ctl($sformatf("rnd%0d", c), e_hold, e_iden, e_bub);
            m_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It tracks destination registers in flight in EX, MEM and WB, and drives the decode stage's forwarding selects and forward data. It also generates load-use stalls, control-flow squashes and fence/system drains. It sits beside the decode stage and sequences fetch, decode and the EX input register.

## Interface
- NUM_REGS, 32, architectural register count; index width is $clog2(NUM_REGS).
- DATA_SIZE, 32, forwarded data width.
- i_aclk  in  1  clock.
- i_areset  in  1  reset. Synchronous, active-high.
- i_id_valid  in  1  decode holds a real, non-NOP instruction.
- i_id_rs1, i_id_rs2  in  $clog2(NUM_REGS)  decode source indices.
- i_id_use_rs1, i_id_use_rs2  in  1  the instruction reads that source.
- i_id_rd  in  $clog2(NUM_REGS)  decode destination.
- i_id_regwrite  in  1  decode instruction writes rd.
- i_id_memtoreg  in  2  00 ALU, 01 load, 10 PC+4.
- i_id_jal  in  1  decode redirects fetch (JAL).
- i_id_drain  in  1  decode holds SYNCH/SYSTEM.
- i_ex_redirect  in  1  EX resolved JALR or taken branch.
- i_ex_fwd_data, i_mem_fwd_data, i_wb_data  in  DATA_SIZE  non-load results of EX and MEM, and the final WB value.
- o_forward_a, o_forward_b  out  1  use forwarded data for rs1/rs2.
- o_fdata_a, o_fdata_b  out  DATA_SIZE  forwarded data.
- o_hold_if  out  1  fetch keeps PC and re-presents its instruction.
- o_hold_id  out  1  decode register keeps its instruction.
- o_id_en  out  1  decode enable; 0 loads a NOP.
- o_bubble_ex  out  1  EX input register loads a NOP.
- o_stall_cycles, o_flush_count  out  32  present only with HAZARD_PERF_EN.

## Operation
**Scoreboard**
- Three slots, EX/MEM/WB, each holding {valid, rd, regwrite, is_load}.
- Each edge: WB<=MEM and MEM<=EX, unconditionally.
- EX<=decode info only when i_id_valid & !o_bubble_ex. Otherwise EX loads an invalid slot.

**Forwarding, per operand**
- A slot matches when it is valid & regwrite & rd==rs & rs!=0 & use_rs.
- Priority is EX > MEM > WB.
- Data source: EX→i_ex_fwd_data, MEM→i_mem_fwd_data, WB→i_wb_data.
- With no match: o_forward=0 and o_fdata=0.

**Load-use stall**
- Raised when the highest-priority match is an EX or MEM slot with is_load.
- During the stall: o_hold_if=1, o_hold_id=1, o_bubble_ex=1, o_forward=0.
- Resulting length: 2 cycles for a dependency on a load in EX, 1 cycle for a load in MEM; the load then forwards from WB.

**FSM states RUN, DRAIN**
- RUN→DRAIN when i_id_valid & i_id_drain & any slot is valid.
- In DRAIN, holds and bubble are asserted, exactly as for a stall.
- DRAIN→RUN on the cycle all three slots are invalid; that cycle releases, with no hold.

**Squash priority (highest first)**
1. i_ex_redirect: o_id_en=0 and o_bubble_ex=1. All holds are 0, overriding stall and DRAIN. FSM returns to RUN.
2. Stall or DRAIN.
3. i_id_jal: o_id_en=0, so the fetched instruction is squashed. No bubble; the JAL itself proceeds.
- Otherwise o_id_en=1 and all other controls are 0.

## Timing
- All outputs are combinational from the slots, the FSM state and the current inputs. Forwarding is visible in the same cycle.
- Scoreboard and FSM update on the rising edge of i_aclk.
- On reset (effective at the next edge): slots invalid, FSM=RUN.
- Outputs after reset: o_id_en=1; every other output 0, including the counters.
- Reset asserted mid-stall or mid-DRAIN: everything is cleared next cycle; no hold persists.
- A WB write to register x collides with a decode read of x: the WB forward covers it, so no regfile write-through is needed.
- Register x0 is never forwarded and never stalls.

## Configuration
- HAZARD_PERF_EN defined:
  - o_stall_cycles increments on each cycle with o_hold_id=1.
  - o_flush_count increments on each cycle with o_id_en=0, where the cause is a redirect or JAL.
  - Both counters are 32-bit, saturating, and cleared by i_areset.
- Undefined: neither port nor either counter exists.

## Structure
- multicore_pkg gains:
  - t_hz_slot struct {valid, rd, regwrite, is_load}.
  - t_hz_state enum {HZ_RUN, HZ_DRAIN}.
  - t_fwd_src enum {FWD_NONE, FWD_EX, FWD_MEM, FWD_WB}.
  - MEMTOREG_LOAD = 2'b01.
- Sub-module hazard_fwd_sel: per-operand match, priority, source and data mux, plus a load-hit flag. Instantiated twice, once per operand.

## Test plan
1. ADD x5 then ADD x6,x5,x0 with i_ex_fwd_data=0x1234 -> cycle 2: o_forward_a=1, o_fdata_a=0x1234, no hold.
2. LW x7 then ADD x8,x7,x7 -> o_hold_id=1 and o_bubble_ex=1 for 2 cycles. Then o_forward_a=o_forward_b=1 with o_fdata=i_wb_data=0xCAFE.
3. Load-use stall, with i_ex_redirect asserted in its first cycle -> that cycle: o_id_en=0, o_bubble_ex=1, o_hold_if=0. The next cycle has no stall.
4. ADDI x0 followed by a reader of x0; also a read of x3 with writers to x3 in both EX and MEM -> x0: o_forward_a=0; x3: EX data is chosen.
5. Three valid slots, then a FENCE in decode -> DRAIN holds for 3 cycles, then releases. FSM is RUN on the 4th cycle.
6. With HAZARD_PERF_EN: scenario 2 then a JAL -> o_stall_cycles=2, o_flush_count=1. Pulse i_areset mid-stall -> both counters 0 and o_id_en=1 next cycle.
